// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared opcodes, precision modes and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_DOUBLE = 1'b1;

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // True for operations that actually exercise the unit.
    function automatic logic op_live(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_req_arbiter_if
// Description : Requester, unit and response signals of the FPU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_req_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [NREQ-1:0]    req_mode;
    logic [64*NREQ-1:0] req_x;
    logic [64*NREQ-1:0] req_y;
    logic [63:0]        fpu_x;
    logic [63:0]        fpu_y;
    logic [1:0]         fpu_op;
    logic               fpu_mode;
    logic [31:0]        fpu_result32;
    logic [63:0]        fpu_result64;
    logic               fpu_overflow;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_data;
    logic               rsp_ovf;
    logic               rsp_err;
    logic               busy;

    // Arbiter side.
    modport master (
        input  req_valid, req_op, req_mode, req_x, req_y,
        input  fpu_result32, fpu_result64, fpu_overflow, rsp_ready,
        output req_ready, fpu_x, fpu_y, fpu_op, fpu_mode,
        output rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err, busy
    );

    // Requesters, unit and consumer side.
    modport slave (
        output req_valid, req_op, req_mode, req_x, req_y,
        output fpu_result32, fpu_result64, fpu_overflow, rsp_ready,
        input  req_ready, fpu_x, fpu_y, fpu_op, fpu_mode,
        input  rsp_valid, rsp_id, rsp_data, rsp_ovf, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_rsp_fifo
// Description : Synchronous response FIFO with occupancy count, no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_rsp_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_data,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fpu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_req_arbiter
// Description : Round-robin sharing of one FP add/mul unit with tagged,
//               in-order, credit-gated responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int FPU_LAT = 1,
    parameter int RSP_DEP = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fpu_req_arbiter_if.master  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FCW = $clog2(RSP_DEP) + 1;
    localparam int CW  = FCW + 1;
    localparam int FW  = 3 + IDW + 64;
    localparam int L   = FPU_LAT - 1;

    state_t           r_state, w_state_nxt;
    logic [IDW-1:0]   r_rr, w_gidx, w_rr_nxt, w_cand;
    logic [IDW:0]     w_sum;
    logic             w_found, w_gmode;
    logic [1:0]       w_gop;
    logic [63:0]      w_gx, w_gy;
    logic             w_conflict, w_credit, w_issue, w_pop, w_capture;
    logic [CW-1:0]    r_inflight, w_used;
    logic [FCW-1:0]   w_fcount;
    logic [63:0]      r_fpu_x, r_fpu_y, w_cap_data;
    logic [1:0]       r_fpu_op;
    logic             r_fpu_mode;
    logic             r_tag_v    [FPU_LAT];
    logic [IDW-1:0]   r_tag_id   [FPU_LAT];
    logic             r_tag_mode [FPU_LAT];
    logic             r_tag_err  [FPU_LAT];
    logic             r_tag_live [FPU_LAT];
    logic [FW-1:0]    w_push_data, w_head;
    logic             w_empty;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        w_cand  = '0;
        w_gop   = OP_IDLE;
        w_gmode = MODE_SINGLE;
        w_gx    = '0;
        w_gy    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
            w_cand = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_gop   = bus.req_op[2*i +: 2];
                w_gmode = bus.req_mode[i];
                w_gx    = bus.req_x[64*i +: 64];
                w_gy    = bus.req_y[64*i +: 64];
            end
        end
    end

    // The pop happening this cycle already frees its credit.
    assign w_pop      = ~w_empty & bus.rsp_ready;
    assign w_used     = r_inflight + CW'(w_fcount) - CW'(w_pop);
    assign w_credit   = (w_used < CW'(RSP_DEP));
    assign w_conflict = w_found && (w_gmode != r_fpu_mode) && (r_inflight != '0);
    assign w_issue    = (r_state == ST_ISSUE) && w_found && !w_conflict && w_credit;
    assign w_rr_nxt   = (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
    assign w_capture  = r_tag_v[L];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ISSUE: if (w_conflict)          w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_inflight == '0)    w_state_nxt = ST_ISSUE;
            default:                           w_state_nxt = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_ISSUE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr       <= '0;
            r_inflight <= '0;
            r_fpu_x    <= '0;
            r_fpu_y    <= '0;
            r_fpu_op   <= OP_IDLE;
            r_fpu_mode <= MODE_SINGLE;
            for (int i = 0; i < FPU_LAT; i++) begin
                r_tag_v[i]    <= 1'b0;
                r_tag_id[i]   <= '0;
                r_tag_mode[i] <= 1'b0;
                r_tag_err[i]  <= 1'b0;
                r_tag_live[i] <= 1'b0;
            end
        end else begin
            r_fpu_op <= OP_IDLE;
            if (w_issue) begin
                r_fpu_x    <= w_gx;
                r_fpu_y    <= w_gy;
                r_fpu_op   <= (w_gop == OP_RSV) ? OP_IDLE : w_gop;
                r_fpu_mode <= w_gmode;
                r_rr       <= w_rr_nxt;
            end
            r_tag_v[0]    <= w_issue;
            r_tag_id[0]   <= w_gidx;
            r_tag_mode[0] <= w_gmode;
            r_tag_err[0]  <= (w_gop == OP_RSV);
            r_tag_live[0] <= op_live(w_gop);
            for (int i = 1; i < FPU_LAT; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_id[i]   <= r_tag_id[i-1];
                r_tag_mode[i] <= r_tag_mode[i-1];
                r_tag_err[i]  <= r_tag_err[i-1];
                r_tag_live[i] <= r_tag_live[i-1];
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_capture);
        end
    end

    // Idle and reserved ops keep a live bit of 0 so their data reads as zero.
    assign w_cap_data  = (r_tag_mode[L] == MODE_DOUBLE) ? bus.fpu_result64
                                                        : {32'b0, bus.fpu_result32};
    assign w_push_data = {r_tag_live[L], r_tag_err[L], bus.fpu_overflow & r_tag_live[L],
                          r_tag_id[L], w_cap_data};

    fpu_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEP)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_capture),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_fcount)
    );

    assign bus.req_ready = w_issue ? (NREQ'(1) << w_gidx) : '0;
    assign bus.fpu_x     = r_fpu_x;
    assign bus.fpu_y     = r_fpu_y;
    assign bus.fpu_op    = r_fpu_op;
    assign bus.fpu_mode  = r_fpu_mode;
    assign bus.rsp_valid = ~w_empty;
    assign bus.rsp_data  = w_head[FW-1] ? w_head[63:0] : 64'd0;
    assign bus.rsp_err   = w_head[FW-2];
    assign bus.rsp_ovf   = w_head[FW-3];
    assign bus.rsp_id    = w_head[64 +: IDW];
    assign bus.busy      = (r_inflight != '0) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fpu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_req_arbiter
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_req_arbiter;
    localparam int NREQ    = 4;
    localparam int FPU_LAT = 1;
    localparam int RSP_DEP = 4;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        ovf;
        logic        err;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    fpu_req_arbiter_if #(.NREQ(NREQ)) bus ();

    fpu_req_arbiter #(
        .NREQ    (NREQ),
        .FPU_LAT (FPU_LAT),
        .RSP_DEP (RSP_DEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_acc   = 0;
    int          m_rr    = 0;
    bit          m_drain = 1'b0;
    logic        m_last_mode = 1'b0;
    logic [1:0]  m_prev_op = 2'd0;
    exp_t        q[$];
    bit          pend   [NREQ];
    logic [1:0]  p_op   [NREQ];
    logic        p_mode [NREQ];
    logic [63:0] p_x    [NREQ];
    logic [63:0] p_y    [NREQ];
    logic        rst_drv;
    logic        tb_rsp_ready;

    // Behavioural arithmetic: integer add/mul, carry or high product is overflow.
    function automatic void calc(input logic [1:0] op, input logic mode,
                                 input logic [63:0] x, input logic [63:0] y,
                                 output logic [63:0] d, output logic ovf);
        logic [64:0]  s;
        logic [32:0]  s32;
        logic [127:0] p;
        logic [63:0]  p32;
        d = 64'd0;
        ovf = 1'b0;
        if (op == 2'd1) begin
            if (mode) begin
                s = {1'b0, x} + {1'b0, y};
                d = s[63:0]; ovf = s[64];
            end else begin
                s32 = {1'b0, x[31:0]} + {1'b0, y[31:0]};
                d = {32'b0, s32[31:0]}; ovf = s32[32];
            end
        end else if (op == 2'd2) begin
            if (mode) begin
                p = {64'b0, x} * {64'b0, y};
                d = p[63:0]; ovf = |p[127:64];
            end else begin
                p32 = {32'b0, x[31:0]} * {32'b0, y[31:0]};
                d = {32'b0, p32[31:0]}; ovf = |p32[63:32];
            end
        end
    endfunction

    // Unit model with FPU_LAT=1: results valid while the operation is presented.
    logic [63:0] u_d64, u_d32;
    logic        u_o64, u_o32;
    always_comb begin
        calc(bus.fpu_op, 1'b1, bus.fpu_x, bus.fpu_y, u_d64, u_o64);
        calc(bus.fpu_op, 1'b0, bus.fpu_x, bus.fpu_y, u_d32, u_o32);
    end
    assign bus.fpu_result64 = u_d64;
    assign bus.fpu_result32 = u_d32[31:0];
    assign bus.fpu_overflow = bus.fpu_mode ? u_o64 : u_o32;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic submit(input int i, input logic [1:0] op, input logic mode,
                          input logic [63:0] x, input logic [63:0] y);
        pend[i] = 1'b1; p_op[i] = op; p_mode[i] = mode; p_x[i] = x; p_y[i] = y;
    endtask

    task automatic apply_inputs();
        rst           = rst_drv;
        bus.rsp_ready = tb_rsp_ready;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]       = pend[i] & rst_drv;
            bus.req_op[2*i +: 2]   = p_op[i];
            bus.req_mode[i]        = p_mode[i];
            bus.req_x[64*i +: 64]  = p_x[i];
            bus.req_y[64*i +: 64]  = p_y[i];
        end
    endtask

    // Evaluated mid-cycle: checks outputs, then advances the model to the next edge.
    task automatic model();
        logic            exp_valid;
        logic [NREQ-1:0] exp_ready;
        int              inflight;
        int              g;
        exp_t            e;
        exp_valid = (q.size() > 0) && (q[0].acc + FPU_LAT < cyc);
        check_val("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
        check_val("busy", 64'(bus.busy), 64'(q.size() != 0));
        check_val("fpu_op", 64'(bus.fpu_op), 64'(m_prev_op));
        if (exp_valid && tb_rsp_ready) begin
            check_val("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
            check_val("rsp_data", bus.rsp_data, q[0].data);
            check_val("rsp_ovf", 64'(bus.rsp_ovf), 64'(q[0].ovf));
            check_val("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
            void'(q.pop_front());
        end
        inflight = 0;
        foreach (q[k]) if (q[k].acc + FPU_LAT >= cyc) inflight++;
        exp_ready = '0;
        m_prev_op = 2'd0;
        if (!rst_drv) begin
            q.delete();
            m_rr = 0; m_drain = 1'b0; m_last_mode = 1'b0;
        end else if (m_drain) begin
            if (inflight == 0) m_drain = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (g < 0 && pend[c]) g = c;
            end
            if (g >= 0) begin
                if (p_mode[g] != m_last_mode && inflight != 0) begin
                    m_drain = 1'b1;
                end else if (q.size() < RSP_DEP) begin
                    exp_ready[g] = 1'b1;
                    e.id = g; e.acc = cyc; e.err = (p_op[g] == 2'd3);
                    calc(e.err ? 2'd0 : p_op[g], p_mode[g], p_x[g], p_y[g], e.data, e.ovf);
                    q.push_back(e);
                    m_rr = (g + 1) % NREQ;
                    m_last_mode = p_mode[g];
                    m_prev_op = e.err ? 2'd0 : p_op[g];
                end
            end
        end
        check_val("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                pend[i] = 1'b0;
                n_acc++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_inputs();
        @(negedge clk);
        model();
    endtask

    initial begin
        int a0;
        int sub;
        bit any;
        for (int i = 0; i < NREQ; i++) submit(i, 2'd0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        rst_drv = 1'b0;
        tb_rsp_ready = 1'b1;
        apply_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_fpu_op", 64'(bus.fpu_op), 64'd0);
        check_val("reset_fpu_x", bus.fpu_x, 64'd0);
        check_val("reset_fpu_mode", 64'(bus.fpu_mode), 64'd0);
        check_val("reset_req_ready", 64'(bus.req_ready), 64'd0);
        rst_drv = 1'b1;

        // Single requester, single-precision add.
        submit(0, 2'd1, 1'b0, 64'h73728bdb, 64'hfa8288c9);
        repeat (4) step();

        // All requesters together, no back-pressure.
        for (int i = 0; i < NREQ; i++)
            submit(i, 2'($urandom_range(1, 2)), 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (8) step();

        // Precision change must drain the unit first.
        submit(1, 2'd2, 1'b0, 64'h8081aa9b, 64'h832bdfa2);
        submit(2, 2'd1, 1'b1, 64'h00a8386612345678, 64'h8187738312332101);
        repeat (8) step();

        // Credits: only RSP_DEP accepted while the consumer stalls.
        tb_rsp_ready = 1'b0;
        a0 = n_acc;
        sub = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && sub < 6) begin
                    submit(i, 2'd1, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
                    sub++;
                end
            end
            step();
        end
        check_val("t4_accepted_stalled", 64'(n_acc - a0), 64'(RSP_DEP));
        tb_rsp_ready = 1'b1;
        repeat (12) step();
        check_val("t4_accepted_total", 64'(n_acc - a0), 64'd6);

        // Reserved op returns an error and keeps the unit idle.
        submit(3, 2'd3, m_last_mode, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (4) step();

        // Reset with work outstanding discards everything.
        tb_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            submit(i, 2'd1, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (4) step();
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
        step();
        check_val("t6_rsp_valid_after_rst", 64'(bus.rsp_valid), 64'd0);
        check_val("t6_busy_after_rst", 64'(bus.busy), 64'd0);
        tb_rsp_ready = 1'b1;
        repeat (4) step();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            tb_rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    int r;
                    logic [1:0] op;
                    r = $urandom_range(0, 9);
                    op = (r == 0) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                    submit(i, op, ($urandom_range(0, 5) == 0), {$urandom(), $urandom()},
                           {$urandom(), $urandom()});
                end
            end
            step();
        end

        tb_rsp_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) any |= pend[i];
            if (q.size() == 0 && !any) break;
            step();
        end
        check_val("final_drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
